// File: rtl/tusca_uc.sv
// TUSCA control unit: Moore FSM sequencing DHT11 reads, serial transmission,
// inter-measurement delay, configuration reception and retry/fault handling.
module tusca_uc #(
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       configurar,
    input  logic       fim_delay,
    input  logic       pronto_medida,
    input  logic       erro_medida,
    input  logic       pronto_config,
    input  logic       erro_config,
    input  logic       pronto_transmite_medida,
    output logic       zera_delay,
    output logic       conta_delay,
    output logic       medir_dht11,
    output logic       receber_config,
    output logic       transmite_medida,
    output logic       gira,
    output logic       falha,
    output logic       db_erro_config,
    output logic [1:0] db_tentativas,
    output logic [3:0] db_estado
);
    localparam int TW = $clog2(MAX_TENTATIVAS + 1);

    typedef enum logic [3:0] {
        INICIAL            = 4'd0,
        PREPARA            = 4'd1,
        PEDE_MEDIDA        = 4'd2,
        ESPERA_MEDIDA      = 4'd3,
        ERRO_MEDIDA        = 4'd4,
        TRANSMITE          = 4'd5,
        ESPERA_TRANSMISSAO = 4'd6,
        ZERA_DELAY         = 4'd7,
        ESPERA_DELAY       = 4'd8,
        PEDE_CONFIG        = 4'd9,
        ESPERA_CONFIG      = 4'd10,
        FALHA              = 4'd15
    } estado_t;

    estado_t         estado, prox_estado;
    logic [TW-1:0]   tentativas;
    logic [TW-1:0]   tent_inc;
    logic            pedido_config;

    assign tent_inc = tentativas + TW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:            prox_estado = ligar ? PREPARA : INICIAL;
            PREPARA:            prox_estado = PEDE_MEDIDA;
            PEDE_MEDIDA:        prox_estado = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                if (erro_medida)        prox_estado = ERRO_MEDIDA;
                else if (pronto_medida) prox_estado = TRANSMITE;
                else                    prox_estado = ESPERA_MEDIDA;
            end
            ERRO_MEDIDA:        prox_estado = (tent_inc == TW'(MAX_TENTATIVAS)) ? FALHA : ZERA_DELAY;
            TRANSMITE:          prox_estado = ESPERA_TRANSMISSAO;
            ESPERA_TRANSMISSAO: prox_estado = pronto_transmite_medida ? ZERA_DELAY : ESPERA_TRANSMISSAO;
            ZERA_DELAY:         prox_estado = ESPERA_DELAY;
            ESPERA_DELAY: begin
                if (!ligar)                         prox_estado = INICIAL;
                else if (fim_delay && pedido_config) prox_estado = PEDE_CONFIG;
                else if (fim_delay)                 prox_estado = PEDE_MEDIDA;
                else                                prox_estado = ESPERA_DELAY;
            end
            PEDE_CONFIG:        prox_estado = ESPERA_CONFIG;
            ESPERA_CONFIG:      prox_estado = (erro_config || pronto_config) ? PEDE_MEDIDA : ESPERA_CONFIG;
            FALHA:              prox_estado = ligar ? FALHA : INICIAL;
            default:            prox_estado = INICIAL;
        endcase
    end

    always_comb begin
        zera_delay       = 1'b0;
        conta_delay      = 1'b0;
        medir_dht11      = 1'b0;
        receber_config   = 1'b0;
        transmite_medida = 1'b0;
        falha            = 1'b0;
        gira             = 1'b1;
        case (estado)
            INICIAL:     gira = 1'b0;
            PREPARA:     zera_delay = 1'b1;
            PEDE_MEDIDA: medir_dht11 = 1'b1;
            TRANSMITE:   transmite_medida = 1'b1;
            ZERA_DELAY:  zera_delay = 1'b1;
            ESPERA_DELAY: conta_delay = 1'b1;
            PEDE_CONFIG: receber_config = 1'b1;
            FALHA: begin
                falha = 1'b1;
                gira  = 1'b0;
            end
            ESPERA_MEDIDA, ERRO_MEDIDA, ESPERA_TRANSMISSAO, ESPERA_CONFIG: ;
            default:     gira = 1'b0;
        endcase
    end

    // Error count is cleared on a fresh start and on every successful read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            tentativas <= '0;
        else if (estado == PREPARA)
            tentativas <= '0;
        else if (estado == ESPERA_MEDIDA && !erro_medida && pronto_medida)
            tentativas <= '0;
        else if (estado == ERRO_MEDIDA)
            tentativas <= tent_inc;
    end

    // A new request arriving on the PEDE_CONFIG cycle must survive the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pedido_config <= 1'b0;
        else if (estado != INICIAL && configurar)
            pedido_config <= 1'b1;
        else if (estado == PEDE_CONFIG || estado == INICIAL)
            pedido_config <= 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            db_erro_config <= 1'b0;
        else if (estado == ESPERA_CONFIG && erro_config)
            db_erro_config <= 1'b1;
        else if (estado == ESPERA_CONFIG && pronto_config)
            db_erro_config <= 1'b0;
    end

    generate
        if (TW >= 2) begin : g_tent_trunc
            assign db_tentativas = tentativas[1:0];
        end else begin : g_tent_ext
            assign db_tentativas = {1'b0, tentativas};
        end
    endgenerate

    assign db_estado = estado;
endmodule

// File: tb/tb_tusca_uc.sv
// Directed bench for tusca_uc: walks the measurement, retry/fault, config,
// power-off and reset paths with hand-computed state/output expectations.
module tb_tusca_uc;
    logic       clock = 1'b0;
    logic       reset, ligar, configurar, fim_delay;
    logic       pronto_medida, erro_medida, pronto_config, erro_config;
    logic       pronto_transmite_medida;
    logic       zera_delay, conta_delay, medir_dht11, receber_config;
    logic       transmite_medida, gira, falha, db_erro_config;
    logic [1:0] db_tentativas;
    logic [3:0] db_estado;

    int n_chk = 0;
    int n_pass = 0;
    int n_tx = 0;
    int tx_saved;

    // {zera, conta, medir, receber, transmite, gira, falha}
    localparam logic [6:0] O_OFF   = 7'b0000000;
    localparam logic [6:0] O_ZERA  = 7'b1000010;
    localparam logic [6:0] O_MED   = 7'b0010010;
    localparam logic [6:0] O_RUN   = 7'b0000010;
    localparam logic [6:0] O_TX    = 7'b0000110;
    localparam logic [6:0] O_DLY   = 7'b0100010;
    localparam logic [6:0] O_CFG   = 7'b0001010;
    localparam logic [6:0] O_FALHA = 7'b0000001;

    logic [6:0] outs;
    assign outs = {zera_delay, conta_delay, medir_dht11, receber_config,
                   transmite_medida, gira, falha};

    tusca_uc #(.MAX_TENTATIVAS(3)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .configurar(configurar),
        .fim_delay(fim_delay), .pronto_medida(pronto_medida),
        .erro_medida(erro_medida), .pronto_config(pronto_config),
        .erro_config(erro_config),
        .pronto_transmite_medida(pronto_transmite_medida),
        .zera_delay(zera_delay), .conta_delay(conta_delay),
        .medir_dht11(medir_dht11), .receber_config(receber_config),
        .transmite_medida(transmite_medida), .gira(gira), .falha(falha),
        .db_erro_config(db_erro_config), .db_tentativas(db_tentativas),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (transmite_medida) n_tx <= n_tx + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic st(input string tag, input logic [3:0] e_st, input logic [6:0] e_out);
        chk({tag, ".estado"}, 32'(db_estado), 32'(e_st));
        chk({tag, ".outs"}, 32'(outs), 32'(e_out));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Run one successful read+transmit from ESPERA_MEDIDA up to ESPERA_DELAY.
    task automatic read_tx_to_delay();
        pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
        tick();
        pronto_transmite_medida = 1'b1; tick(); pronto_transmite_medida = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ligar = 1'b0; configurar = 1'b0; fim_delay = 1'b0;
        pronto_medida = 1'b0; erro_medida = 1'b0; pronto_config = 1'b0;
        erro_config = 1'b0; pronto_transmite_medida = 1'b0;
        tick(); tick();
        st("reset", 4'd0, O_OFF);
        chk("reset.tent", 32'(db_tentativas), 32'd0);
        chk("reset.errcfg", 32'(db_erro_config), 32'd0);

        // Startup and first read
        reset = 1'b0; ligar = 1'b1;
        tick(); st("prepara", 4'd1, O_ZERA);
        tick(); st("pede_medida", 4'd2, O_MED);
        tick(); st("espera_medida", 4'd3, O_RUN);
        tick(); st("espera_medida_hold", 4'd3, O_RUN);
        pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
        st("transmite", 4'd5, O_TX);
        tick(); st("espera_tx", 4'd6, O_RUN);
        tick(); st("espera_tx_hold", 4'd6, O_RUN);
        pronto_transmite_medida = 1'b1; tick(); pronto_transmite_medida = 1'b0;
        st("zera_delay", 4'd7, O_ZERA);
        tick(); st("espera_delay", 4'd8, O_DLY);
        tick(); st("espera_delay_hold", 4'd8, O_DLY);
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        st("remede", 4'd2, O_MED);
        chk("tx_count1", 32'(n_tx), 32'd1);
        tick();

        // Three consecutive errors; last one coincides with pronto_medida
        tx_saved = n_tx;
        erro_medida = 1'b1; tick(); erro_medida = 1'b0;
        st("erro1", 4'd4, O_RUN);
        tick(); st("erro1_zd", 4'd7, O_ZERA);
        chk("tent1", 32'(db_tentativas), 32'd1);
        tick(); fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        st("retry1", 4'd2, O_MED);
        tick();
        erro_medida = 1'b1; tick(); erro_medida = 1'b0;
        tick(); st("erro2_zd", 4'd7, O_ZERA);
        chk("tent2", 32'(db_tentativas), 32'd2);
        tick(); fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        tick();
        erro_medida = 1'b1; pronto_medida = 1'b1; tick();
        erro_medida = 1'b0; pronto_medida = 1'b0;
        st("erro_wins", 4'd4, O_RUN);
        tick(); st("falha", 4'd15, O_FALHA);
        chk("tent3", 32'(db_tentativas), 32'd3);
        tick(); st("falha_hold", 4'd15, O_FALHA);
        chk("no_tx_in_retries", 32'(n_tx), 32'(tx_saved));
        ligar = 1'b0; tick(); st("falha_off", 4'd0, O_OFF);

        // Config request during a read, error then success
        ligar = 1'b1; tick(); tick();
        chk("tent_cleared", 32'(db_tentativas), 32'd0);
        tick();
        configurar = 1'b1; tick(); configurar = 1'b0;
        read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        st("pede_config", 4'd9, O_CFG);
        tick(); st("espera_config", 4'd10, O_RUN);
        erro_config = 1'b1; tick(); erro_config = 1'b0;
        st("cfg_err_next", 4'd2, O_MED);
        chk("errcfg_set", 32'(db_erro_config), 32'd1);
        tick(); read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        st("pedido_cleared", 4'd2, O_MED);
        tick();
        configurar = 1'b1; tick(); configurar = 1'b0;
        read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        tick();
        pronto_config = 1'b1; tick(); pronto_config = 1'b0;
        st("cfg_ok_next", 4'd2, O_MED);
        chk("errcfg_clr", 32'(db_erro_config), 32'd0);

        // Power-off mid-read completes the transmission first
        tick();
        ligar = 1'b0; tick(); st("off_in_read", 4'd3, O_RUN);
        pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
        st("off_still_tx", 4'd5, O_TX);
        tick();
        pronto_transmite_medida = 1'b1; tick(); pronto_transmite_medida = 1'b0;
        tick(); st("off_delay", 4'd8, O_DLY);
        tick(); st("off_inicial", 4'd0, O_OFF);

        // Async reset in ESPERA_CONFIG with pending request and sticky error
        ligar = 1'b1; tick(); tick(); tick();
        configurar = 1'b1; tick(); configurar = 1'b0;
        read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        tick();
        erro_config = 1'b1; tick(); erro_config = 1'b0;
        tick();
        configurar = 1'b1; tick(); configurar = 1'b0;
        read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        configurar = 1'b1; tick(); configurar = 1'b0;
        st("pre_reset", 4'd10, O_RUN);
        chk("pre_reset.errcfg", 32'(db_erro_config), 32'd1);
        #2 reset = 1'b1;
        #1 st("async_reset", 4'd0, O_OFF);
        chk("async_reset.errcfg", 32'(db_erro_config), 32'd0);
        tick(); reset = 1'b0;
        tick(); tick(); tick();
        read_tx_to_delay();
        fim_delay = 1'b1; tick(); fim_delay = 1'b0;
        st("pedido_reset", 4'd2, O_MED);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tusca_uc.md
Name: tusca_uc

Overview:
- Control unit (Moore FSM) for the TUSCA datapath; drives its command inputs and consumes its status outputs.
- Each cycle: measures the DHT11 and transmits the measurement over serial, then waits the inter-measurement delay.
- Services configuration-reception requests between cycles, retries failed measurements, and enters a latched fault state after too many consecutive failures.
- Keeps the servo sweeping while the system is on.

Parameters:
MAX_TENTATIVAS, 3, consecutive measurement errors that force FALHA (>=1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ligar  input  1  level; 1 = system on
configurar  input  1  one-cycle pulse requesting configuration reception
fim_delay  input  1  delay counter terminal count
pronto_medida  input  1  DHT11 read done (pulse)
erro_medida  input  1  DHT11 read failed (pulse)
pronto_config  input  1  configuration received OK (pulse)
erro_config  input  1  configuration reception failed (pulse)
pronto_transmite_medida  input  1  serial transmission done (pulse)
zera_delay  output  1  synchronous clear of delay counter
conta_delay  output  1  delay counter enable
medir_dht11  output  1  one-cycle start of DHT11 read
receber_config  output  1  one-cycle start of config reception
transmite_medida  output  1  one-cycle start of transmission
gira  output  1  servo sweep enable
falha  output  1  fault indicator
db_erro_config  output  1  sticky: last config attempt failed
db_tentativas  output  2  current consecutive-error count
db_estado  output  4  state code

Behaviour:
- State register, tentativas counter, pedido_config latch and db_erro_config flag all use the async active-high reset. All outputs are 0 in reset (state INICIAL).
- Moore outputs, decoded from state only; command pulses last exactly one cycle.
- States (code), with outputs and transitions:
  - INICIAL (0): all outputs 0. ligar=1 -> PREPARA.
  - PREPARA (1): zera_delay=1; tentativas<=0 -> PEDE_MEDIDA.
  - PEDE_MEDIDA (2): medir_dht11=1 -> ESPERA_MEDIDA.
  - ESPERA_MEDIDA (3): erro_medida -> ERRO_MEDIDA; else pronto_medida -> TRANSMITE (tentativas<=0); else stay. If both pulse together, erro wins.
  - ERRO_MEDIDA (4): tentativas<=tentativas+1. If tentativas+1==MAX_TENTATIVAS -> FALHA, else -> ZERA_DELAY (retry after a full delay; no transmission).
  - TRANSMITE (5): transmite_medida=1 -> ESPERA_TRANSMISSAO.
  - ESPERA_TRANSMISSAO (6): pronto_transmite_medida -> ZERA_DELAY.
  - ZERA_DELAY (7): zera_delay=1 -> ESPERA_DELAY.
  - ESPERA_DELAY (8): conta_delay=1. Exits, in priority order:
    - ligar=0 -> INICIAL.
    - fim_delay with pedido_config=1 -> PEDE_CONFIG.
    - fim_delay -> PEDE_MEDIDA.
  - PEDE_CONFIG (9): receber_config=1; clears pedido_config -> ESPERA_CONFIG.
  - ESPERA_CONFIG (10): erro_config -> PEDE_MEDIDA, db_erro_config<=1. Else pronto_config -> PEDE_MEDIDA, db_erro_config<=0. Simultaneous: erro wins.
  - FALHA (15): falha=1, gira=0. ligar=0 -> INICIAL; otherwise holds.
- gira=1 in every state except INICIAL and FALHA.
- ligar=0 is honoured only in ESPERA_DELAY and FALHA; in-flight read/transmit/config always completes first.
- pedido_config:
  - Set by a configurar pulse in any state except INICIAL.
  - Cleared on the PEDE_CONFIG cycle; a set in that same cycle wins (request retained).
  - Cleared on re-entry to INICIAL.
- db_tentativas = tentativas; counter width is ceil(log2(MAX_TENTATIVAS+1)), zero-extended or truncated to 2 bits.
- Unused codes (11-14) -> INICIAL on the next clock.
- Reset mid-operation: immediate return to INICIAL, all flags cleared.

Test Plan:
1. Reset, then ligar=1 -> PREPARA (zera_delay=1) -> PEDE_MEDIDA: medir_dht11 high for exactly 1 cycle; gira=1 from PREPARA on.
2. pronto_medida pulse -> transmite_medida 1 cycle; pronto_transmite_medida -> zera_delay 1 cycle, then conta_delay=1 until fim_delay -> medir_dht11 again (db_estado 3,5,6,7,8,2).
3. MAX_TENTATIVAS=3, erro_medida on three consecutive reads -> db_tentativas 1, 2 with a delay between retries; third error -> FALHA, falha=1, gira=0, no transmite_medida ever issued.
4. configurar pulse during ESPERA_MEDIDA -> normal transmit, delay, then receber_config 1 cycle. erro_config -> db_erro_config=1 and next read starts; next config with pronto_config -> db_erro_config=0.
5. ligar=0 during ESPERA_MEDIDA -> stays until pronto_medida, transmits, then INICIAL at ESPERA_DELAY with all outputs 0. ligar=0 in FALHA -> INICIAL.
6. Simultaneous erro_medida+pronto_medida -> ERRO_MEDIDA. Async reset asserted in ESPERA_CONFIG -> db_estado=0 immediately, pedido_config and db_erro_config cleared.
